// File: rtl/multi_word_pkg.sv
// Shared definitions for the multi-word shift-register family: serializer
// state encoding and a width helper used to size word counters.
package multi_word_pkg;

    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    // Bits needed to index n words; never less than 1 so that a 1-word frame
    // still gets a legal counter.
    function automatic int clog2_min1(input int n);
        int bits;
        bits = 0;
        while ((1 << bits) < n) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/multi_word_load_shift_register.sv
// POSITIONS x WIDTH register with parallel load, shift toward word 0 with zero
// fill at the top, and synchronous clear. Load takes priority over shift.
module multi_word_load_shift_register #(
    parameter int POSITIONS = 8,
    parameter int WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       shift,
    input  logic [POSITIONS*WIDTH-1:0] pin,
    output logic [WIDTH-1:0]           word0
);

    logic [POSITIONS-1:0][WIDTH-1:0] r_words;

    // NOTE: every word is cleared on reset so a stale frame can never leak
    // out as so after a reset; the register is small enough that this costs
    // nothing worth avoiding.
    // NOTE: sequential state is written with <= so every word samples the
    // pre-edge value of its neighbour; = here would smear one word down the
    // whole register in a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_words <= '0;
        end else if (load) begin
            r_words <= pin;
        end else if (shift) begin
            // A logical right shift by one word moves word i+1 into word i
            // and zero-fills the top word, including the POSITIONS=1 case.
            r_words <= r_words >> WIDTH;
        end
    end

    assign word0 = r_words[0];

endmodule

// File: rtl/multi_word_frame_serializer.sv
// Parallel-in, serial-out frame serializer: captures POSITIONS words in one
// handshake and streams them out word 0 first with first/last markers.
module multi_word_frame_serializer
    import multi_word_pkg::*;
#(
    parameter int POSITIONS = 8,
    parameter int WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [POSITIONS*WIDTH-1:0] frame_in,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    output logic [WIDTH-1:0]           so,
    output logic                       so_valid,
    input  logic                       so_ready,
    output logic                       so_first,
    output logic                       so_last,
    output logic                       busy
);

    localparam int IDX_W = clog2_min1(POSITIONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POSITIONS - 1);

    logic             r_state;
    logic [IDX_W-1:0] r_idx;

    logic             w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_load;
    logic             w_beat;
    logic             w_shift;
    logic             w_at_last;
    logic [WIDTH-1:0] w_word0;

    assign so_valid  = (r_state == SHIFT);
    assign busy      = so_valid;
    assign w_at_last = (r_idx == LAST_IDX);
    assign so_first  = so_valid && (r_idx == '0);
    assign so_last   = so_valid && w_at_last;

    // Ready again on the closing beat of a frame so frames can run back to
    // back without an idle cycle between them.
    assign frame_ready = !rst && (!so_valid || (so_ready && so_last));

    assign w_load  = frame_valid && frame_ready;
    assign w_beat  = so_valid && so_ready;
    assign w_shift = w_beat && !w_load;

    // NOTE: both next-state signals get a default before any branch, so no
    // path through this block leaves them unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_load) begin
            w_state_nxt = SHIFT;
            w_idx_nxt   = '0;
        end else if (w_beat) begin
            if (w_at_last) begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    multi_word_load_shift_register #(
        .POSITIONS(POSITIONS),
        .WIDTH    (WIDTH)
    ) u_shift_reg (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .shift(w_shift),
        .pin  (frame_in),
        .word0(w_word0)
    );

    // Gating by so_valid keeps so at 0 whenever the stream is idle.
    assign so = so_valid ? w_word0 : '0;

endmodule

// File: tb/tb_multi_word_frame_serializer.sv
// Directed bench for multi_word_frame_serializer: a 4x8 instance for the main
// scenarios and a 1x8 instance for the single-word frame corner.
module tb_multi_word_frame_serializer;

    localparam int P = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [P*W-1:0] frame_in;
    logic           frame_valid;
    logic           frame_ready;
    logic [W-1:0]   so;
    logic           so_valid;
    logic           so_ready;
    logic           so_first;
    logic           so_last;
    logic           busy;

    logic [W-1:0]   frame_in1;
    logic           frame_valid1;
    logic           frame_ready1;
    logic [W-1:0]   so1;
    logic           so_valid1;
    logic           so_ready1;
    logic           so_first1;
    logic           so_last1;
    logic           busy1;

    int n_checks;
    int n_fail;

    multi_word_frame_serializer #(.POSITIONS(P), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .so         (so),
        .so_valid   (so_valid),
        .so_ready   (so_ready),
        .so_first   (so_first),
        .so_last    (so_last),
        .busy       (busy)
    );

    multi_word_frame_serializer #(.POSITIONS(1), .WIDTH(W)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .frame_in   (frame_in1),
        .frame_valid(frame_valid1),
        .frame_ready(frame_ready1),
        .so         (so1),
        .so_valid   (so_valid1),
        .so_ready   (so_ready1),
        .so_first   (so_first1),
        .so_last    (so_last1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well
    // clear of the rising edge that updates the design.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_stream(input string tag, input logic v, input logic [W-1:0] d,
                                input logic f, input logic l, input logic fr);
        check({tag, ".so_valid"},    32'(so_valid),    32'(v));
        check({tag, ".so"},          32'(so),          32'(d));
        check({tag, ".so_first"},    32'(so_first),    32'(f));
        check({tag, ".so_last"},     32'(so_last),     32'(l));
        check({tag, ".frame_ready"}, 32'(frame_ready), 32'(fr));
        check({tag, ".busy"},        32'(busy),        32'(v));
    endtask

    localparam logic [P*W-1:0] FRAME_A = 32'h4433_2211;
    localparam logic [P*W-1:0] FRAME_B = 32'hA4A3_A2A1;

    initial begin
        logic [W-1:0] exp_a  [4];
        logic [W-1:0] exp_b  [4];
        logic         rdy_pat[7];
        logic [W-1:0] exp_st [7];

        exp_a   = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_b   = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_st  = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44};

        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        frame_in     = '0;
        frame_valid  = 1'b0;
        so_ready     = 1'b0;
        frame_in1    = '0;
        frame_valid1 = 1'b0;
        so_ready1    = 1'b0;

        // Reset, with frame_valid high to show rst wins over a load.
        next_cycle();
        next_cycle();
        frame_in    = FRAME_A;
        frame_valid = 1'b1;
        settle();
        check_stream("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Basic frame, so_ready held high.
        next_cycle();
        rst      = 1'b0;
        so_ready = 1'b1;
        settle();
        check_stream("basic.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        next_cycle();
        frame_valid = 1'b0;
        for (int i = 0; i < P; i++) begin
            settle();
            check_stream($sformatf("basic.w%0d", i), 1'b1, exp_a[i], i == 0, i == P - 1, i == P - 1);
            next_cycle();
        end
        settle();
        check_stream("basic.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Same frame with a stalling consumer.
        frame_in    = FRAME_A;
        frame_valid = 1'b1;
        next_cycle();
        frame_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            so_ready = rdy_pat[i];
            settle();
            check_stream($sformatf("stall.c%0d", i), 1'b1, exp_st[i], i == 0, i >= 6,
                         i == 6);
            next_cycle();
        end
        so_ready = 1'b1;
        settle();
        check_stream("stall.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Back-to-back frames; frame B waits with frame_valid high throughout
        // frame A and may only be taken on A's last beat.
        frame_in    = FRAME_A;
        frame_valid = 1'b1;
        next_cycle();
        frame_in = FRAME_B;
        for (int i = 0; i < P; i++) begin
            settle();
            check_stream($sformatf("b2b.a%0d", i), 1'b1, exp_a[i], i == 0, i == P - 1, i == P - 1);
            next_cycle();
        end
        frame_valid = 1'b0;
        for (int i = 0; i < P; i++) begin
            settle();
            check_stream($sformatf("b2b.b%0d", i), 1'b1, exp_b[i], i == 0, i == P - 1, i == P - 1);
            next_cycle();
        end
        settle();
        check_stream("b2b.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset after the second beat, with a frame offered at the same time.
        frame_in    = FRAME_A;
        frame_valid = 1'b1;
        next_cycle();
        frame_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check_stream($sformatf("rstmid.w%0d", i), 1'b1, exp_a[i], i == 0, 1'b0, 1'b0);
            next_cycle();
        end
        rst         = 1'b1;
        frame_in    = FRAME_B;
        frame_valid = 1'b1;
        settle();
        check("rstmid.frame_ready_in_rst", 32'(frame_ready), 32'd0);
        next_cycle();
        rst = 1'b0;
        settle();
        check_stream("rstmid.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        next_cycle();
        frame_valid = 1'b0;
        settle();
        check_stream("rstmid.restart", 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < P; i++) begin
            next_cycle();
        end
        next_cycle();
        settle();
        check_stream("rstmid.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Single-word frame instance.
        frame_in1    = 8'h5A;
        frame_valid1 = 1'b1;
        so_ready1    = 1'b1;
        settle();
        check("p1.idle.frame_ready", 32'(frame_ready1), 32'd1);
        check("p1.idle.so_valid",    32'(so_valid1),    32'd0);
        next_cycle();
        frame_valid1 = 1'b0;
        settle();
        check("p1.so",          32'(so1),          32'h5A);
        check("p1.so_valid",    32'(so_valid1),    32'd1);
        check("p1.so_first",    32'(so_first1),    32'd1);
        check("p1.so_last",     32'(so_last1),     32'd1);
        check("p1.frame_ready", 32'(frame_ready1), 32'd1);
        check("p1.busy",        32'(busy1),        32'd1);
        next_cycle();
        settle();
        check("p1.end.so_valid", 32'(so_valid1), 32'd0);
        check("p1.end.so",       32'(so1),       32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_word_frame_serializer.md
Name: multi_word_frame_serializer

Overview:
- Parallel-in, serial-out word serializer.
- Accepts one frame of POSITIONS words, each WIDTH bits, in a single valid/ready handshake.
- Emits the frame one word per accepted beat on a valid/ready stream, word 0 first, with first and last markers.
- Transmit-side counterpart of the word-wide shift-register delay line; feeds word streams into it and into downstream consumers.

Parameters:
- POSITIONS, 8, words per frame (>=1).
- WIDTH, 8, bits per word (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- frame_in  input  POSITIONS*WIDTH  parallel frame; word i = frame_in[i*WIDTH +: WIDTH].
- frame_valid  input  1  frame_in holds a frame.
- frame_ready  output  1  serializer can load a frame this cycle.
- so  output  WIDTH  current serial word.
- so_valid  output  1  so is valid.
- so_ready  input  1  consumer accepts so this cycle.
- so_first  output  1  so is word 0 of the frame.
- so_last  output  1  so is word POSITIONS-1 of the frame.
- busy  output  1  frame in flight (equals so_valid).

Behaviour:
- Single clock domain. rst is synchronous and active-high. All state updates occur on posedge clk.
- Reset values:
  - so=0, so_valid=0, so_first=0, so_last=0, busy=0.
  - Word counter idx=0. All shift-register words cleared to 0.
  - frame_ready=0 while rst is high.
- States:
  - IDLE (so_valid=0).
  - SHIFT (so_valid=1).
- Load: a load occurs when frame_valid && frame_ready at an edge.
  - All POSITIONS words are captured.
  - State becomes SHIFT. idx=0.
  - so = word 0 from the next cycle. Load-to-first-word latency is 1 cycle.
- frame_ready (combinational):
  - 1 in IDLE.
  - 1 in SHIFT only when so_ready && so_last, which permits back-to-back frames with no bubble.
  - 0 otherwise and during rst.
- Beat: a beat occurs when so_valid && so_ready at an edge.
  - Register shifts toward word 0. The vacated top word is filled with 0.
  - idx increments.
- Stall: while so_valid && !so_ready, the values of so, so_first and so_last are held stable. No shift and no idx change.
- Markers (registered or decoded from idx, glitch-free relative to clk):
  - so_first = so_valid && idx==0.
  - so_last = so_valid && idx==POSITIONS-1.
- End of frame: on a beat with so_last:
  - If frame_valid is high, the new frame loads and SHIFT continues with idx=0.
  - Otherwise the state returns to IDLE, so_valid=0, and so=0.
- POSITIONS=1: so_first and so_last are asserted together on the single word.
- idx width is max(1, clog2(POSITIONS)). idx never exceeds POSITIONS-1 (no wrap past the frame).
- frame_valid in SHIFT without the last-beat condition is ignored. The upstream must hold it; it is not captured.
- Reset mid-frame: the in-flight frame is discarded. Outputs take reset values on the cycle after the rst edge. No partial frame resumes.
- rst together with frame_valid: rst wins, nothing is loaded.
- Throughput: one word per cycle when so_ready is tied high. POSITIONS cycles per frame.

Decomposition:
- Shared package multi_word_pkg holds:
  - State encoding constants IDLE=1'b0 and SHIFT=1'b1.
  - A clog2 helper function shared with other shift-register blocks.
- Natural sub-module multi_word_load_shift_register:
  - POSITIONS x WIDTH parallel-load, shift-enable register with zero fill and synchronous clear.
  - Ports: clk, rst, load, shift, pin, word0.
- The top level keeps the FSM, counter, markers and handshake logic.

Test Plan (POSITIONS=4, WIDTH=8 unless noted):
- Reset then load frame {0x44,0x33,0x22,0x11} (word0=0x11) with so_ready=1 -> so=0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after load. so_first on 0x11, so_last on 0x44. Then so_valid=0 and so=0.
- Same frame with so_ready toggling 1,0,0,1,0,1,1 -> each word is held stable while stalled. Exactly 4 beats occur, in order, with no duplication.
- Two frames (0x11..0x44 then 0xA1..0xA4) presented back-to-back with so_ready=1 -> 8 contiguous valid cycles. frame_ready pulses high only on the 0x44 beat. 0xA1 is flagged so_first.
- frame_valid held high during SHIFT before the last beat -> frame_ready=0 and no capture. The second frame loads only on the last beat of the first.
- rst asserted for 1 cycle after the 2nd beat -> next cycle so_valid=0, so=0, busy=0. A new frame then starts at word 0.
- POSITIONS=1, frame 0x5A -> single beat with so=0x5A and so_first=so_last=1. frame_ready=1 on that beat.
